// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage of the pipelined MIPS datapath.
//
// Owns the program counter and drives the instruction-memory request.
// Presents the fetched word, its PC and PC+4 to the IF/ID register.
// Accepts taken branch/jump redirects and a halt seen at write-back.
// While a miss is outstanding, the memory address is held stable.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   ihit, imemload       memory data valid / instruction word
//   imemREN, imemaddr    memory read request / address (always the PC)
//   freeze               hazard stall: hold PC, do not consume the word
//   redirect,redirect_pc taken branch/jump and its target
//   halt                 halt observed at write-back
//   instruction_out, pc_out, npc_out   IF/ID payload
//   valid_out            payload is a usable fetch this cycle
//   flush_out            redirect accepted this cycle, IF/ID must flush
//   fetch_count          instructions consumed since reset
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        freeze,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic [31:0] npc_out,
  output logic        valid_out,
  output logic        flush_out,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pending_pc_q;
  logic        halt_pend_q;
  logic [31:0] fetch_count_q;
  logic [31:0] target_d;

  // Targets are forced onto a word boundary.
  assign target_d = redirect_pc & 32'hFFFF_FFFC;

  assign imemaddr        = pc_q;
  assign imemREN         = (state_q != HALTED);
  assign instruction_out = imemload;
  assign pc_out          = pc_q;
  assign npc_out         = pc_q + 32'd4;
  assign fetch_count     = fetch_count_q;
  assign valid_out       = ihit & (state_q == FETCH) & ~redirect;
  // In FETCH a halt outranks the redirect, so the redirect is not taken.
  assign flush_out       = redirect & (((state_q == FETCH) & ~halt) | (state_q == DRAIN));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= FETCH;
      pc_q          <= PC_INIT;
      pending_pc_q  <= 32'd0;
      halt_pend_q   <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      case (state_q)
        FETCH: begin
          if (halt) begin
            if (ihit) begin
              state_q <= HALTED;
            end else begin
              // Outstanding miss must complete before stopping.
              state_q     <= DRAIN;
              halt_pend_q <= 1'b1;
            end
          end else if (redirect) begin
            if (ihit) begin
              pc_q <= target_d;
            end else begin
              // Keep the address stable until the in-flight miss returns.
              pending_pc_q <= target_d;
              state_q      <= DRAIN;
            end
          end else if (ihit && !freeze) begin
            pc_q          <= pc_q + 32'd4;
            fetch_count_q <= fetch_count_q + 32'd1;
          end
        end
        DRAIN: begin
          if (redirect) pending_pc_q <= target_d;
          if (halt) halt_pend_q <= 1'b1;
          if (ihit) begin
            // Returned data belongs to a squashed address and is dropped.
            if (halt_pend_q || halt) begin
              state_q <= HALTED;
            end else begin
              pc_q    <= redirect ? target_d : pending_pc_q;
              state_q <= FETCH;
            end
          end
        end
        HALTED: begin
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        freeze;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic [31:0] npc_out;
  logic        valid_out;
  logic        flush_out;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t sb[$];

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .freeze(freeze),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instruction_out(instruction_out), .pc_out(pc_out), .npc_out(npc_out),
    .valid_out(valid_out), .flush_out(flush_out), .fetch_count(fetch_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return (pc ^ 32'h5A5A_0000) + 32'h0000_1234;
  endfunction

  // Scoreboard consumer: every presented fetch must match the next pushed one.
  always @(negedge CLK) begin
    if (nRST && valid_out) begin
      if (sb.size() == 0) begin
        check_val("sb_spurious", {31'd0, valid_out}, 32'd0);
      end else begin
        fetch_t e;
        e = sb.pop_front();
        check_val("sb_pc", pc_out, e.pc);
        check_val("sb_npc", npc_out, e.npc);
        check_val("sb_instr", instruction_out, e.instr);
        $display("fetch pc=%08h npc=%08h instr=%08h", pc_out, npc_out, instruction_out);
      end
    end
  end

  // One clock cycle of stimulus plus the combinational checks for it.
  task automatic step(input logic ih, input logic fr, input logic rd, input logic [31:0] rpc,
                      input logic hl, input logic [31:0] exp_addr, input logic exp_valid,
                      input logic exp_flush, input logic exp_ren);
    fetch_t e;
    @(posedge CLK);
    #1;
    ihit = ih; freeze = fr; redirect = rd; redirect_pc = rpc; halt = hl;
    imemload = mk_instr(exp_addr);
    if (exp_valid) begin
      e.pc = exp_addr; e.npc = exp_addr + 32'd4; e.instr = mk_instr(exp_addr);
      sb.push_back(e);
    end
    #3;
    check_val("imemaddr", imemaddr, exp_addr);
    check_val("valid_out", {31'd0, valid_out}, {31'd0, exp_valid});
    check_val("flush_out", {31'd0, flush_out}, {31'd0, exp_flush});
    check_val("imemREN", {31'd0, imemREN}, {31'd0, exp_ren});
    $display("cycle addr=%08h ihit=%0b frz=%0b redir=%0b halt=%0b valid=%0b flush=%0b cnt=%0d",
             imemaddr, ih, fr, rd, hl, valid_out, flush_out, fetch_count);
  endtask

  task automatic do_reset();
    ihit = 0; freeze = 0; redirect = 0; redirect_pc = 0; halt = 0; imemload = 0;
    nRST = 0;
    #2;
    check_val("rst_addr", imemaddr, 32'h0);
    check_val("rst_ren", {31'd0, imemREN}, 32'd1);
    check_val("rst_fcnt", fetch_count, 32'd0);
    check_val("rst_flush", {31'd0, flush_out}, 32'd0);
    check_val("rst_valid", {31'd0, valid_out}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1;
    $display("reset released");
  endtask

  initial begin
    ihit = 0; freeze = 0; redirect = 0; redirect_pc = 0; halt = 0; imemload = 0;
    nRST = 0;
    #1;
    do_reset();

    // Sequential fetch with a two-cycle freeze at pc 8.
    step(1, 0, 0, 32'h0, 0, 32'h00, 1, 0, 1);
    step(1, 0, 0, 32'h0, 0, 32'h04, 1, 0, 1);
    step(1, 1, 0, 32'h0, 0, 32'h08, 1, 0, 1);
    check_val("fcnt_frz1", fetch_count, 32'd2);
    step(1, 1, 0, 32'h0, 0, 32'h08, 1, 0, 1);
    check_val("fcnt_frz2", fetch_count, 32'd2);
    step(1, 0, 0, 32'h0, 0, 32'h08, 1, 0, 1);
    step(1, 0, 0, 32'h0, 0, 32'h0C, 1, 0, 1);
    // Redirect with hit at 0x10 -> 0x40.
    step(1, 0, 1, 32'h40, 0, 32'h10, 0, 1, 1);
    check_val("fcnt_4", fetch_count, 32'd4);
    step(1, 0, 0, 32'h0, 0, 32'h40, 1, 0, 1);
    step(1, 0, 1, 32'h20, 0, 32'h44, 0, 1, 1);
    check_val("fcnt_5", fetch_count, 32'd5);
    // Redirect on a miss at 0x20, re-redirect while draining.
    step(0, 0, 1, 32'h80, 0, 32'h20, 0, 1, 1);
    step(0, 0, 0, 32'h0, 0, 32'h20, 0, 0, 1);
    step(0, 0, 1, 32'hC0, 0, 32'h20, 0, 1, 1);
    step(1, 0, 0, 32'h0, 0, 32'h20, 0, 0, 1);
    check_val("fcnt_drain", fetch_count, 32'd5);
    step(1, 0, 0, 32'h0, 0, 32'hC0, 1, 0, 1);
    // Misaligned target and freeze not blocking a redirect.
    step(1, 0, 1, 32'h45, 0, 32'hC4, 0, 1, 1);
    check_val("fcnt_6", fetch_count, 32'd6);
    step(1, 1, 1, 32'hFFFF_FFFF, 0, 32'h44, 0, 1, 1);
    // PC wrap at the top of the address space.
    step(1, 0, 0, 32'h0, 0, 32'hFFFF_FFFC, 1, 0, 1);
    step(1, 0, 0, 32'h0, 0, 32'h00, 1, 0, 1);
    check_val("fcnt_7", fetch_count, 32'd7);
    // Halt with hit, then stay halted.
    step(1, 0, 0, 32'h0, 1, 32'h04, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, logic'(i % 2), 32'h200, 0, 32'h04, 0, 0, 0);
    end
    check_val("fcnt_halt", fetch_count, 32'd8);
    do_reset();

    // Reset while draining discards the pending target.
    step(1, 0, 0, 32'h0, 0, 32'h00, 1, 0, 1);
    step(0, 0, 1, 32'h100, 0, 32'h04, 0, 1, 1);
    step(0, 0, 0, 32'h0, 0, 32'h04, 0, 0, 1);
    do_reset();
    step(1, 0, 0, 32'h0, 0, 32'h00, 1, 0, 1);
    // Halt on a miss: drain, then halt on the next hit.
    step(0, 0, 0, 32'h0, 1, 32'h04, 0, 0, 1);
    step(0, 0, 0, 32'h0, 0, 32'h04, 0, 0, 1);
    step(1, 0, 0, 32'h0, 0, 32'h04, 0, 0, 1);
    step(1, 0, 0, 32'h0, 0, 32'h04, 0, 0, 0);
    check_val("fcnt_end", fetch_count, 32'd1);

    @(negedge CLK);
    #1;
    check_val("sb_left", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the pipelined MIPS datapath. It owns the program counter, drives the instruction-memory request, and presents the fetched instruction, its PC and PC+4 to the IF/ID pipeline register. It absorbs branch/jump redirects from later stages and a halt from write-back. It keeps the memory address stable across outstanding misses so the cache handshake is never violated.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded at reset (word aligned)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction memory returns valid data this cycle
- imemload  in  32  instruction word from memory
- imemREN  out  1  instruction read request
- imemaddr  out  32  instruction read address
- freeze  in  1  hazard stall; hold PC, do not consume instruction
- redirect  in  1  branch/jump resolved taken; squash and refetch
- redirect_pc  in  32  redirect target
- halt  in  1  halt observed at write-back
- instruction_out  out  32  fetched instruction (to IF/ID instructionin)
- pc_out  out  32  PC of fetched instruction (to IF/ID pcin)
- npc_out  out  32  pc_out + 4 (to IF/ID npcin)
- valid_out  out  1  instruction_out is a usable fetch this cycle
- flush_out  out  1  redirect accepted this cycle; IF/ID must flush
- fetch_count  out  32  instructions consumed since reset

## Operation
- Registers: pc (32), pending_pc (32), state, fetch_count.
- States: FETCH, DRAIN, HALTED.
- imemaddr = pc in all states; imemREN = 1 in FETCH and DRAIN, 0 in HALTED.
- instruction_out = imemload, pc_out = pc, npc_out = pc + 4 (mod 2^32, wraps at 32'hFFFF_FFFC -> 0).
- valid_out = ihit & (state == FETCH) & ~redirect.
- FETCH, priority high to low:
  - halt: -> HALTED if ihit; else -> DRAIN with pending_pc unchanged and halt latched.
  - redirect & ihit: pc <= {redirect_pc[31:2],2'b00}; stay FETCH; flush_out = 1.
  - redirect & ~ihit: pending_pc <= {redirect_pc[31:2],2'b00}; -> DRAIN; flush_out = 1.
  - ihit & ~freeze: pc <= pc + 4; fetch_count++.
  - otherwise hold.
- DRAIN (miss in flight to a squashed address; pc held stable):
  - new redirect overwrites pending_pc, flush_out = 1.
  - halt latches halt-pending.
  - on ihit: discard data (valid_out = 0); if halt-pending -> HALTED, else pc <= pending_pc, -> FETCH.
- HALTED: all registers hold; valid_out = 0; exits only via nRST.
- freeze never blocks a redirect or halt.
- fetch_count wraps at 2^32 - 1 -> 0.

## Timing
- Reset (async, nRST low): pc = PC_INIT, pending_pc = 0, halt-pending = 0, fetch_count = 0, state = FETCH; hence imemREN = 1, imemaddr = PC_INIT, valid_out = 0 unless ihit, flush_out = 0.
- Fetch latency: instruction presented same cycle as ihit; PC advances on that edge; back-to-back hits give one instruction per cycle.
- Redirect with ihit: new PC visible one cycle after redirect.
- Redirect without ihit: new PC visible the cycle after the first ihit following the redirect.
- flush_out is combinational, one cycle per accepted redirect.
- Reset asserted mid-DRAIN discards pending_pc; fetch restarts at PC_INIT.

## Test plan
- Reset then ihit=1 every cycle, freeze=0 -> imemaddr 0,4,8,12; valid_out=1 each cycle; fetch_count=4 after 4 cycles.
- freeze=1 for 2 cycles at pc=8 with ihit=1 -> imemaddr stays 8, fetch_count unchanged, resumes at 12 after freeze drops.
- redirect=1, redirect_pc=0x40, ihit=1 at pc=0x10 -> flush_out=1, valid_out=0, next imemaddr 0x40.
- redirect to 0x80 with ihit=0 at pc=0x20, ihit 3 cycles later; second redirect to 0xC0 during wait -> imemaddr stays 0x20 until ihit, data discarded, then imemaddr 0xC0.
- halt=1 with ihit=1 -> next cycle imemREN=0, valid_out=0; stays halted 10 cycles; nRST pulse -> imemaddr=PC_INIT, imemREN=1.
- redirect_pc=0x45 -> pc loads 0x44; pc at 0xFFFF_FFFC with ihit -> npc_out 0, next imemaddr 0.
